tc_m: RTL and testbench
=======================

# tc_m

Memory-mapped countdown timer on the M-stage store/load bus, addressed alongside the data memory. It takes the same word address, write data and write enable that the M stage presents to data memory, returns read data for the bridge's load mux, and raises an interrupt request to the CP0 stage. Upstream M-stage logic gates `WE` so that the block sees only word stores that hit its window.

## Interface
Parameters:
- `BASE`, default `32'h0000_7F00`: base of the 16-byte register window.

Ports:
- `Clk` input 1: clock. All state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Addr` input 32: M-stage byte address.
- `WD` input 32: store data.
- `WE` input 1: word-store strobe, already qualified by the bridge.
- `RD` output 32: combinational read data.
- `IRQ` output 1: interrupt request, equal to `irq_pend & CTRL[3]`.

## Operation
- Select: `Addr[31:4] == BASE[31:4]`. The offset is `Addr[3:2]`.
  - Offset 0 is `CTRL`. Bits [3:0] are writable: [3] IM, [2:1] Mode, [0] Enable. Bits [31:4] read as 0.
  - Offset 1 is `PRESET`, 32-bit, read/write.
  - Offset 2 is `COUNT`, read-only. Writes to it are ignored.
  - Offset 3 is unmapped: reads 0, writes ignored.
- `RD` is a pure function of `Addr` and the registers; `WE` does not affect it. When not selected, `RD` is 0.
- A write is `WE & select & valid offset`. Register contents update at the edge. The FSM reacts to the new value on the following cycle.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable, go to LOAD.
  - LOAD: `COUNT <= PRESET`, go to CNT.
  - CNT:
    - If !Enable, go to IDLE with COUNT held and no interrupt.
    - Else if `COUNT <= 1`: `COUNT <= 0`, `irq_pend <= 1`, go to INT.
    - Else `COUNT <= COUNT - 1`.
  - INT, Mode 0 (also 2 and 3): `CTRL[0] <= 0`, go to IDLE. `irq_pend` stays set.
  - INT, Mode 1: `irq_pend <= 0`, go to LOAD (auto-reload).
- `irq_pend` is cleared by any write to CTRL or PRESET.
- Priorities:
  - A hardware set of `irq_pend` wins over a software clear at the same edge.
  - A software CTRL write wins over the INT-state clear of Enable at the same edge.
- A PRESET write during CNT does not disturb COUNT. The new value is used at the next LOAD.
- COUNT never wraps. It saturates at 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, IRQ=0. `RD` reflects these zeros immediately.
- Reset asserted mid-count aborts to IDLE asynchronously. No interrupt is generated.
- Worked example, Mode 0, PRESET=N≥1, write Enable=1 at edge E0:
  - E1: IDLE→LOAD.
  - E2: COUNT=N, state CNT.
  - E(N+1): COUNT=1.
  - E(N+2): COUNT=0, state INT, IRQ high (if IM).
  - E(N+3): Enable=0, state IDLE. IRQ stays high until a CTRL or PRESET write.
- PRESET=0 behaves like PRESET=1: INT is entered one edge after LOAD.
- Mode 1: IRQ is high for exactly one cycle per period. Period is PRESET+2 cycles for PRESET≥1.
- Read latency is zero, combinational.

## Configuration
- `TC_AUTORELOAD_EN` defined: Mode 1 behaves as described above.
- `TC_AUTORELOAD_EN` undefined: Mode 1 is treated as Mode 0.
  - The Mode field remains writable and readable.
  - INT always clears Enable and holds `irq_pend`.

## Test plan
- Reset then read offsets 0/4/8/C → RD=0 for all; IRQ=0.
- PRESET=3, CTRL=0x9 (IM=1, Mode 0, Enable) at E0:
  - COUNT reads 3, 2, 1, 0 at E2–E5.
  - IRQ rises after E5.
  - CTRL reads 0x8 after E6.
  - IRQ falls only after a later CTRL write.
- PRESET=2, CTRL=0xB (Mode 1) → IRQ single-cycle pulses every 4 cycles, indefinitely. Without `TC_AUTORELOAD_EN`: exactly one pulse, then IRQ held high.
- Clear Enable while COUNT=5 in CNT → state IDLE, COUNT frozen at 5, no IRQ. Re-enable reloads from PRESET.
- Write PRESET=7 during CNT → current run is unaffected. The next Mode-1 reload loads 7.
- Store to `BASE+8` and `BASE+C` → no register change. A CTRL write with IM=0 at IRQ time → `irq_pend` sets, but IRQ stays 0.

Source files
------------

// File: rtl/tc_m.sv
// tc_m: memory-mapped countdown timer (CTRL/PRESET/COUNT) with interrupt; `TC_AUTORELOAD_EN enables Mode 1 auto-reload
module tc_m #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        IRQ
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_pend_q, irq_pend_d;
    logic        sel, wr_ctrl, wr_preset, reload, irq_set, irq_hw_clr;
    logic [1:0]  off;
    logic        unused_addr;

    assign sel         = Addr[31:4] == BASE[31:4];
    assign off         = Addr[3:2];
    assign wr_ctrl     = WE & sel & (off == 2'd0);
    assign wr_preset   = WE & sel & (off == 2'd1);
    assign unused_addr = ^Addr[1:0];

`ifdef TC_AUTORELOAD_EN
    assign reload = ctrl_q[2:1] == 2'd1;
`else
    assign reload = 1'b0;
`endif

    // Read mux: purely a function of the address and the register contents
    always_comb begin
        RD = 32'd0;
        if (sel) begin
            case (off)
                2'd0:    RD = {28'd0, ctrl_q};
                2'd1:    RD = preset_q;
                2'd2:    RD = count_q;
                default: RD = 32'd0;
            endcase
        end
    end

    assign IRQ = irq_pend_q & ctrl_q[3];

    // Next state: FSM first, then software writes override, then the hardware irq set wins last
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_set    = 1'b0;
        irq_hw_clr = 1'b0;
        case (state_q)
            S_IDLE: state_d = ctrl_q[0] ? S_LOAD : S_IDLE;
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d = 32'd0;
                    irq_set = 1'b1;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: begin
                if (reload) begin
                    irq_hw_clr = 1'b1;
                    state_d    = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
        endcase
        if (wr_ctrl) ctrl_d = WD[3:0];
        if (wr_preset) preset_d = WD;
        irq_pend_d = irq_set ? 1'b1 : (wr_ctrl | wr_preset | irq_hw_clr) ? 1'b0 : irq_pend_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end
endmodule

// File: tb/tb_tc_m.sv
// tb_tc_m: directed self-checking bench for the tc_m countdown timer
module tb_tc_m;
    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TC_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WD = 32'd0;
    logic        WE = 1'b0;
    logic [31:0] RD;
    logic        IRQ;
    int checks = 0;
    int errors = 0;

    tc_m #(.BASE(BASE)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .WD(WD), .WE(WE), .RD(RD), .IRQ(IRQ)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge Clk);
        Addr = a;
        WD = d;
        WE = 1'b1;
        @(posedge Clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, RD, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    initial begin
        // reset state
        #2;
        chk_rd("rst_in_ctrl", BASE, 32'd0);
        #10;
        Reset = 1'b0;
        tick();
        chk_rd("rst_ctrl", BASE + 32'h0, 32'd0);
        chk_rd("rst_preset", BASE + 32'h4, 32'd0);
        chk_rd("rst_count", BASE + 32'h8, 32'd0);
        chk_rd("rst_unmapped", BASE + 32'hC, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // Mode 0 one-shot, PRESET=3
        wr(BASE + 32'h4, 32'd3);
        chk_rd("m0_preset", BASE + 32'h4, 32'd3);
        wr(BASE, 32'h9);
        Addr = BASE + 32'h8;
        tick(); chk_rd("m0_e1", BASE + 32'h8, 32'd0);
        tick(); chk_rd("m0_e2", BASE + 32'h8, 32'd3);
        tick(); chk_rd("m0_e3", BASE + 32'h8, 32'd2);
        tick(); chk_rd("m0_e4", BASE + 32'h8, 32'd1);
        chk_irq("m0_irq_e4", 1'b0);
        tick(); chk_rd("m0_e5", BASE + 32'h8, 32'd0);
        chk_irq("m0_irq_e5", 1'b1);
        tick(); chk_rd("m0_ctrl_e6", BASE, 32'h8);
        chk_irq("m0_irq_e6", 1'b1);
        tick(3);
        chk_irq("m0_irq_held", 1'b1);
        chk_rd("m0_count_sat", BASE + 32'h8, 32'd0);
        wr(BASE, 32'h8);
        chk_irq("m0_irq_cleared", 1'b0);

        // Mode 1, PRESET=2: pulse every 4 cycles (or one pulse then held without auto-reload)
        wr(BASE + 32'h4, 32'd2);
        wr(BASE, 32'hB);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk_irq($sformatf("m1_irq_e%0d", i), AR ? (i % 4 == 0) : (i >= 4));
        end
        chk_rd("m1_ctrl", BASE, AR ? 32'hB : 32'hA);
        wr(BASE, 32'h0);
        tick(3);
        chk_irq("m1_off_irq", 1'b0);

        // disable while COUNT=5 freezes it; re-enable reloads
        wr(BASE + 32'h4, 32'd8);
        wr(BASE, 32'h9);
        tick(4);
        chk_rd("dis_e4", BASE + 32'h8, 32'd6);
        wr(BASE, 32'h8);
        chk_rd("dis_e5", BASE + 32'h8, 32'd5);
        tick(4);
        chk_rd("dis_frozen", BASE + 32'h8, 32'd5);
        chk_irq("dis_irq", 1'b0);
        wr(BASE, 32'h9);
        tick();
        chk_rd("reen_e1", BASE + 32'h8, 32'd5);
        tick();
        chk_rd("reen_e2", BASE + 32'h8, 32'd8);
        wr(BASE, 32'h0);
        tick(3);

        // PRESET write during CNT leaves the run alone; next reload uses it
        wr(BASE + 32'h4, 32'd3);
        wr(BASE, 32'hB);
        tick(2);
        chk_rd("pw_e2", BASE + 32'h8, 32'd3);
        wr(BASE + 32'h4, 32'd7);
        chk_rd("pw_e3", BASE + 32'h8, 32'd2);
        tick(); chk_rd("pw_e4", BASE + 32'h8, 32'd1);
        tick(); chk_rd("pw_e5", BASE + 32'h8, 32'd0);
        chk_irq("pw_irq_e5", 1'b1);
        tick(); chk_irq("pw_irq_e6", !AR);
        tick(); chk_rd("pw_e7", BASE + 32'h8, AR ? 32'd7 : 32'd0);
        chk_rd("pw_preset", BASE + 32'h4, 32'd7);
        wr(BASE, 32'h0);
        tick(2);

        // writes to COUNT, unmapped offset and outside the window change nothing
        wr(BASE + 32'h8, 32'hDEAD);
        chk_rd("ro_count", BASE + 32'h8, AR ? 32'd6 : 32'd0);
        wr(BASE + 32'hC, 32'hF);
        chk_rd("unm_rd", BASE + 32'hC, 32'd0);
        chk_rd("unm_ctrl", BASE, 32'h0);
        chk_rd("unm_preset", BASE + 32'h4, 32'd7);
        wr(BASE + 32'h10, 32'hF);
        chk_rd("oow_ctrl", BASE, 32'h0);

        // IM=0: interrupt fires internally but IRQ stays low
        wr(BASE + 32'h4, 32'd1);
        wr(BASE, 32'h1);
        tick(2);
        chk_rd("im0_e2", BASE + 32'h8, 32'd1);
        tick();
        chk_rd("im0_e3", BASE + 32'h8, 32'd0);
        chk_irq("im0_irq_e3", 1'b0);
        tick();
        chk_rd("im0_ctrl_e4", BASE, 32'h0);
        chk_irq("im0_irq_e4", 1'b0);

        // hardware set beats software clear; software CTRL write beats INT Enable clear
        wr(BASE, 32'h1);
        tick(2);
        chk_irq("pri_irq_e2", 1'b0);
        wr(BASE, 32'h9);
        chk_irq("pri_hwset", 1'b1);
        wr(BASE, 32'h9);
        chk_rd("pri_ctrl_kept", BASE, 32'h9);
        chk_irq("pri_swclr", 1'b0);
        tick(2);
        chk_rd("pri_reload", BASE + 32'h8, 32'd1);
        chk_rd("oow_rd", BASE + 32'h10, 32'd0);
        wr(BASE, 32'h0);
        tick(3);

        // asynchronous reset mid-count
        wr(BASE + 32'h4, 32'd5);
        wr(BASE, 32'h9);
        tick(3);
        chk_rd("ar_e3", BASE + 32'h8, 32'd4);
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        chk_rd("ar_count", BASE + 32'h8, 32'd0);
        chk_rd("ar_ctrl", BASE, 32'd0);
        chk_rd("ar_preset", BASE + 32'h4, 32'd0);
        chk_irq("ar_irq", 1'b0);
        tick(2);
        Reset = 1'b0;
        tick(4);
        chk_rd("ar_after", BASE + 32'h8, 32'd0);
        chk_irq("ar_irq_after", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
